reg_wr_arbiter: RTL and testbench

REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

---
 rtl/reg_wr_pkg.sv | 17 +
 rtl/reg_wr_arbiter_rr_arb2.sv | 32 +++
 rtl/reg_wr_arbiter.sv | 143 ++++++++++++++
 tb/tb_reg_wr_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_wr_pkg.sv
// Shared definitions for the register-file write arbiter: field widths,
// register count and the controller state encoding.
package reg_wr_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  // Highest register index; the zero-fill sweep ends after writing it.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    INIT = 1'b0,  // zero-fill sweep of registers 1..31
    ARB  = 1'b1   // normal arbitration between the two writeback ports
  } state_e;

endpackage

// File: rtl/reg_wr_arbiter_rr_arb2.sv
// rr_arb2: two-requester grant logic. Round-robin on the previous winner
// when FIXED_PRIO is 0; requester 0 always wins a tie when FIXED_PRIO is 1.
// Purely combinational; at most one grant per cycle.
module rr_arb2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic en,
  input  logic v0,
  input  logic v1,
  input  logic last_grant,
  output logic gnt0,
  output logic gnt1
);

  // Resolve the grant from the valids and the previous winner.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (v0 && v1) begin
        // A tie goes to the requester that did not win last time.
        if ((FIXED_PRIO != 0) || last_grant) gnt0 = 1'b1;
        else                                 gnt1 = 1'b1;
      end else begin
        gnt0 = v0;
        gnt1 = v1;
      end
    end
  end

endmodule

// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter: arbitrates ALU (port 0) and load (port 1) writebacks onto
// a single register-file write port with a one-cycle registered output.
// Writes to register 0 are accepted and dropped.
// Build option: define REG_WR_ARBITER_INIT_SWEEP_EN to zero-fill registers
// 1..31 after reset (busy high meanwhile); otherwise the block resets
// straight into arbitration and busy is tied low.
module reg_wr_arbiter
  import reg_wr_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] wt_addr,
  output logic [DATA_W-1:0] wt_data,
  output logic              l_s,
  output logic              busy,
  output logic              last_grant
);

  logic              arb_en;
  logic              sweep_active;
  logic [ADDR_W-1:0] sweep_addr;
  logic              gnt0;
  logic              gnt1;

  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] wt_addr_q, wt_addr_d;
  logic [DATA_W-1:0] wt_data_q, wt_data_d;
  logic              l_s_q, l_s_d;

`ifdef REG_WR_ARBITER_INIT_SWEEP_EN
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  assign arb_en       = (state_q == ARB);
  assign sweep_active = (state_q == INIT);
  assign sweep_addr   = cnt_q;
  assign busy         = (state_q == INIT);

  // Sweep sequencing: step the counter 1..31, then hand over to arbitration.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      if (cnt_q == LAST_ADDR) begin
        // Hold the counter at 31 rather than wrapping to 0.
        state_d = ARB;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end
  end

  // Sweep state and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      cnt_q   <= ADDR_W'(1);
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign arb_en       = 1'b1;
  assign sweep_active = 1'b0;
  assign sweep_addr   = '0;
  assign busy         = 1'b0;
`endif

  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_rr_arb2 (
    .en         (arb_en),
    .v0         (req0_valid),
    .v1         (req1_valid),
    .last_grant (last_grant_q),
    .gnt0       (gnt0),
    .gnt1       (gnt1)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Next write-port contents: sweep write, accepted request, or hold.
  always_comb begin
    last_grant_d = last_grant_q;
    wt_addr_d    = wt_addr_q;
    wt_data_d    = wt_data_q;
    l_s_d        = 1'b0;
    if (sweep_active) begin
      wt_addr_d = sweep_addr;
      wt_data_d = '0;
      l_s_d     = 1'b1;
    end else if (gnt0) begin
      last_grant_d = 1'b0;
      // Register 0 is hard-wired: accept the request but do not write.
      if (req0_addr != '0) begin
        wt_addr_d = req0_addr;
        wt_data_d = req0_data;
        l_s_d     = 1'b1;
      end
    end else if (gnt1) begin
      last_grant_d = 1'b1;
      if (req1_addr != '0) begin
        wt_addr_d = req1_addr;
        wt_data_d = req1_data;
        l_s_d     = 1'b1;
      end
    end
  end

  // Output write register and grant history; reset favours requester 0 first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
      wt_addr_q    <= '0;
      wt_data_q    <= '0;
      l_s_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      wt_addr_q    <= wt_addr_d;
      wt_data_q    <= wt_data_d;
      l_s_q        <= l_s_d;
    end
  end

  assign wt_addr    = wt_addr_q;
  assign wt_data    = wt_data_q;
  assign l_s        = l_s_q;
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter. Two instances share the request inputs:
// dut_rr (round-robin) and dut_fp (fixed priority). Sweep-specific scenarios
// are selected with REG_WR_ARBITER_INIT_SWEEP_EN, matching the RTL build.
module tb_reg_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0;
  logic [4:0]  req0_addr  = '0;
  logic [31:0] req0_data  = '0;
  logic        req1_valid = 1'b0;
  logic [4:0]  req1_addr  = '0;
  logic [31:0] req1_data  = '0;

  logic        rr_ready0, rr_ready1, rr_l_s, rr_busy, rr_last;
  logic [4:0]  rr_addr;
  logic [31:0] rr_data;
  logic        fp_ready0, fp_ready1, fp_l_s, fp_busy, fp_last;
  logic [4:0]  fp_addr;
  logic [31:0] fp_data;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  reg_wr_arbiter #(.FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req0_ready(rr_ready0), .req1_ready(rr_ready1),
    .wt_addr(rr_addr), .wt_data(rr_data), .l_s(rr_l_s),
    .busy(rr_busy), .last_grant(rr_last)
  );

  reg_wr_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req0_ready(fp_ready0), .req1_ready(fp_ready1),
    .wt_addr(fp_addr), .wt_data(fp_data), .l_s(fp_l_s),
    .busy(fp_busy), .last_grant(fp_last)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (3) tick();
    total++; if (rr_l_s !== 1'b0) $display("FAIL reset_l_s: got %b want 0", rr_l_s); else passed++;
    total++; if (rr_addr !== 5'd0) $display("FAIL reset_addr: got %0d want 0", rr_addr); else passed++;
    total++; if (rr_data !== 32'd0) $display("FAIL reset_data: got %h want 0", rr_data); else passed++;
    total++; if (rr_last !== 1'b1) $display("FAIL reset_last_grant: got %b want 1", rr_last); else passed++;
    total++; if (fp_last !== 1'b1) $display("FAIL reset_fp_last_grant: got %b want 1", fp_last); else passed++;
    total++; if ({rr_ready0, rr_ready1} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {rr_ready0, rr_ready1}); else passed++;
`ifdef REG_WR_ARBITER_INIT_SWEEP_EN
    total++; if (rr_busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", rr_busy); else passed++;
`else
    total++; if (rr_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", rr_busy); else passed++;
`endif
  endtask

  // Release reset; with the sweep built in, watch all 31 zero-fill writes.
  task automatic test_sweep();
    @(negedge clk);
    rst = 1'b1;
`ifdef REG_WR_ARBITER_INIT_SWEEP_EN
    // Busy is already high in the cycle before the first sweep edge.
    total++; if (rr_busy !== 1'b1) $display("FAIL sweep_busy_start: got %b want 1", rr_busy); else passed++;
    for (int k = 1; k <= 31; k++) begin
      tick();
      total++; if (rr_l_s !== 1'b1) $display("FAIL sweep_l_s[%0d]: got %b want 1", k, rr_l_s); else passed++;
      total++; if (rr_addr !== 5'(k)) $display("FAIL sweep_addr[%0d]: got %0d want %0d", k, rr_addr, k); else passed++;
      total++; if (rr_data !== 32'd0) $display("FAIL sweep_data[%0d]: got %h want 0", k, rr_data); else passed++;
      total++; if (rr_busy !== (k < 31)) $display("FAIL sweep_busy[%0d]: got %b want %b", k, rr_busy, (k < 31)); else passed++;
      total++; if (rr_ready0 !== 1'b0 && k < 31) $display("FAIL sweep_ready[%0d]: got %b want 0", k, rr_ready0); else passed++;
    end
`else
    tick();
    total++; if (rr_busy !== 1'b0) $display("FAIL arb_busy: got %b want 0", rr_busy); else passed++;
    total++; if (rr_l_s !== 1'b0) $display("FAIL arb_idle_l_s: got %b want 0", rr_l_s); else passed++;
`endif
    // Arbitration must be usable right away.
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h0000_0055;
    #1;
    total++; if (rr_ready0 !== 1'b1) $display("FAIL first_arb_ready: got %b want 1", rr_ready0); else passed++;
    tick();
    idle_inputs();
    total++; if (rr_l_s !== 1'b1) $display("FAIL first_arb_l_s: got %b want 1", rr_l_s); else passed++;
    total++; if (rr_addr !== 5'd4) $display("FAIL first_arb_addr: got %0d want 4", rr_addr); else passed++;
    total++; if (rr_data !== 32'h0000_0055) $display("FAIL first_arb_data: got %h want 00000055", rr_data); else passed++;
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
    #1;
    total++; if (rr_ready0 !== 1'b1) $display("FAIL single_ready0: got %b want 1", rr_ready0); else passed++;
    total++; if (rr_ready1 !== 1'b0) $display("FAIL single_ready1: got %b want 0", rr_ready1); else passed++;
    tick();
    idle_inputs();
    total++; if (rr_addr !== 5'd5) $display("FAIL single_addr: got %0d want 5", rr_addr); else passed++;
    total++; if (rr_data !== 32'hDEAD_BEEF) $display("FAIL single_data: got %h want deadbeef", rr_data); else passed++;
    total++; if (rr_l_s !== 1'b1) $display("FAIL single_l_s: got %b want 1", rr_l_s); else passed++;
    total++; if (rr_last !== 1'b0) $display("FAIL single_last_grant: got %b want 0", rr_last); else passed++;
    tick();
    total++; if (rr_l_s !== 1'b0) $display("FAIL hold_l_s: got %b want 0", rr_l_s); else passed++;
    total++; if (rr_addr !== 5'd5) $display("FAIL hold_addr: got %0d want 5", rr_addr); else passed++;
    total++; if (rr_data !== 32'hDEAD_BEEF) $display("FAIL hold_data: got %h want deadbeef", rr_data); else passed++;
  endtask

  task automatic test_addr_zero();
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h0000_1234;
    #1;
    total++; if (rr_ready1 !== 1'b1) $display("FAIL zero_ready1: got %b want 1", rr_ready1); else passed++;
    tick();
    idle_inputs();
    total++; if (rr_l_s !== 1'b0) $display("FAIL zero_l_s: got %b want 0", rr_l_s); else passed++;
    total++; if (rr_last !== 1'b1) $display("FAIL zero_last_grant: got %b want 1", rr_last); else passed++;
  endtask

  // Both valid for four cycles; last_grant is 1 on entry, so 0 wins first.
  task automatic test_round_robin();
    logic [3:0] exp_g;
    exp_g = 4'b1010;  // bit i = expected winner in cycle i
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hAAAA_0007;
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'hBBBB_0009;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if ({rr_ready1, rr_ready0} !== (exp_g[i] ? 2'b10 : 2'b01))
        $display("FAIL rr_ready[%0d]: got r1r0=%b%b want winner %0d", i, rr_ready1, rr_ready0, exp_g[i]); else passed++;
      tick();
      total++; if (rr_last !== exp_g[i]) $display("FAIL rr_last_grant[%0d]: got %b want %b", i, rr_last, exp_g[i]); else passed++;
      total++; if (rr_addr !== (exp_g[i] ? 5'd9 : 5'd7)) $display("FAIL rr_addr[%0d]: got %0d want %0d", i, rr_addr, exp_g[i] ? 9 : 7); else passed++;
      total++; if (rr_data !== (exp_g[i] ? 32'hBBBB_0009 : 32'hAAAA_0007)) $display("FAIL rr_data[%0d]: got %h", i, rr_data); else passed++;
      total++; if (rr_l_s !== 1'b1) $display("FAIL rr_l_s[%0d]: got %b want 1", i, rr_l_s); else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_fixed_prio();
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hAAAA_0007;
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'hBBBB_0009;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({fp_ready1, fp_ready0} !== 2'b01) $display("FAIL fp_ready[%0d]: got r1r0=%b%b want 01", i, fp_ready1, fp_ready0); else passed++;
      tick();
      total++; if (fp_addr !== 5'd7) $display("FAIL fp_addr[%0d]: got %0d want 7", i, fp_addr); else passed++;
      total++; if (fp_last !== 1'b0) $display("FAIL fp_last_grant[%0d]: got %b want 0", i, fp_last); else passed++;
    end
    req0_valid = 1'b0;
    #1;
    total++; if (fp_ready1 !== 1'b1) $display("FAIL fp_ready1_after_drop: got %b want 1", fp_ready1); else passed++;
    tick();
    idle_inputs();
    total++; if (fp_addr !== 5'd9) $display("FAIL fp_addr_req1: got %0d want 9", fp_addr); else passed++;
    total++; if (fp_data !== 32'hBBBB_0009) $display("FAIL fp_data_req1: got %h want bbbb0009", fp_data); else passed++;
    total++; if (fp_last !== 1'b1) $display("FAIL fp_last_req1: got %b want 1", fp_last); else passed++;
  endtask

  // Reset in the middle of an operation aborts it with no further write pulse.
  task automatic test_reset_mid();
`ifdef REG_WR_ARBITER_INIT_SWEEP_EN
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int k = 1; k <= 10; k++) tick();
    total++; if (rr_addr !== 5'd10) $display("FAIL mid_sweep_addr: got %0d want 10", rr_addr); else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if (rr_l_s !== 1'b0) $display("FAIL mid_sweep_l_s: got %b want 0", rr_l_s); else passed++;
    total++; if (rr_addr !== 5'd0) $display("FAIL mid_sweep_addr_rst: got %0d want 0", rr_addr); else passed++;
    tick();
    total++; if (rr_l_s !== 1'b0) $display("FAIL mid_sweep_held_l_s: got %b want 0", rr_l_s); else passed++;
    @(negedge clk); rst = 1'b1;
    tick();
    total++; if (rr_addr !== 5'd1 || rr_l_s !== 1'b1) $display("FAIL restart_addr: got %0d l_s=%b want 1 l_s=1", rr_addr, rr_l_s); else passed++;
    tick();
    total++; if (rr_addr !== 5'd2) $display("FAIL restart_addr2: got %0d want 2", rr_addr); else passed++;
`else
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h0000_0033;
    tick();
    idle_inputs();
    total++; if (rr_l_s !== 1'b1) $display("FAIL mid_xfer_l_s_pre: got %b want 1", rr_l_s); else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if (rr_l_s !== 1'b0) $display("FAIL mid_xfer_l_s: got %b want 0", rr_l_s); else passed++;
    total++; if (rr_last !== 1'b1) $display("FAIL mid_xfer_last_grant: got %b want 1", rr_last); else passed++;
    @(negedge clk); rst = 1'b1;
    tick();
    total++; if (rr_l_s !== 1'b0) $display("FAIL after_rst_l_s: got %b want 0", rr_l_s); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_single();
    test_addr_zero();
    test_round_robin();
    test_fixed_prio();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
